regfile_writeback: RTL and testbench

Writeback stage driving the write port of the 32×32 register file. Accepts completed results from the ALU and memory units via valid/ready handshakes, arbitrates round-robin, registers one write per cycle onto the register-file write port, and maintains a 32-bit busy scoreboard of in-flight destinations. It also provides same-cycle forwarding for the two register-file read ports. Sits between the execute/memory units and the register file; the decode stage reads its busy and forward outputs.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/wb_arbiter.sv | 30 +++
 rtl/regfile_writeback.sv | 77 +++++++
 tb/tb_regfile_writeback.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file geometry and writeback source encoding shared by the writeback stage.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {WB_ALU, WB_MEM} wb_src_t;

    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] address);
        return NUM_REGS'(1) << address;
    endfunction

endpackage

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-source round-robin grant; ready doubles as the accept strobe.
module wb_arbiter
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic alu_ready,
    output logic mem_ready
);

    wb_src_t last_grant;

    // On a tie the source that did not win the previous transfer goes first.
    always_comb begin
        alu_ready = !reset && alu_valid && (!mem_valid || last_grant == WB_MEM);
        mem_ready = !reset && mem_valid && (!alu_valid || last_grant == WB_ALU);
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= WB_ALU;
        else if (alu_ready)
            last_grant <= WB_ALU;
        else if (mem_ready)
            last_grant <= WB_MEM;
    end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU/MEM results onto the register-file write port,
// tracks in-flight destinations and forwards the pending write to both read ports.
module regfile_writeback
    import cpu_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_address,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_address,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_address,
    output logic                rf_write_enable,
    output logic [ADDR_W-1:0]   rf_write_address,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic [NUM_REGS-1:0] busy,
    input  logic [ADDR_W-1:0]   read_address1,
    input  logic [ADDR_W-1:0]   read_address2,
    output logic                forward1_valid,
    output logic [DATA_W-1:0]   forward1_data,
    output logic                forward2_valid,
    output logic [DATA_W-1:0]   forward2_data
);

    logic [NUM_REGS-1:0] clear_mask;
    logic [NUM_REGS-1:0] set_mask;

    wb_arbiter u_arbiter (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .alu_ready (alu_ready),
        .mem_ready (mem_ready)
    );

    // Clear is applied before set so a same-edge re-issue keeps the register busy.
    always_comb begin
        clear_mask = rf_write_enable ? reg_mask(rf_write_address) : '0;
        set_mask   = issue_valid ? reg_mask(issue_address) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_enable  <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
            busy             <= '0;
        end else begin
            rf_write_enable <= alu_ready || mem_ready;
            if (alu_ready) begin
                rf_write_address <= alu_address;
                rf_write_data    <= alu_data;
            end else if (mem_ready) begin
                rf_write_address <= mem_address;
                rf_write_data    <= mem_data;
            end
            busy <= (busy & ~clear_mask) | set_mask;
        end
    end

    always_comb begin
        forward1_valid = !reset && rf_write_enable && rf_write_address == read_address1;
        forward2_valid = !reset && rf_write_enable && rf_write_address == read_address2;
        forward1_data  = forward1_valid ? rf_write_data : '0;
        forward2_data  = forward2_valid ? rf_write_data : '0;
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed scenarios plus random traffic checked against a cycle model.
module tb_regfile_writeback;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  alu_address = '0, mem_address = '0, issue_address = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic [4:0]  read_address1 = '0, read_address2 = '0;
    logic        alu_ready, mem_ready, rf_write_enable;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data, busy, forward1_data, forward2_data;
    logic        forward1_valid, forward2_valid;

    regfile_writeback dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_address(alu_address), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_address(mem_address), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_address(issue_address),
        .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
        .busy(busy), .read_address1(read_address1), .read_address2(read_address2),
        .forward1_valid(forward1_valid), .forward1_data(forward1_data),
        .forward2_valid(forward2_valid), .forward2_data(forward2_data)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file fed by the DUT write port, and the model's own view of it.
    logic [31:0] rf_dut [32] = '{default: '0};
    always @(posedge clk)
        if (rf_write_enable) rf_dut[rf_write_address] <= rf_write_data;

    bit          m_we = 0;
    int          m_addr = 0;
    logic [31:0] m_data = '0;
    bit          m_last_mem = 0;
    bit          m_busy [32];
    logic [31:0] rf_model [32] = '{default: '0};
    bit          ga, gm;

    function automatic logic [31:0] busy_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // One clock: check combinational outputs, advance the model across the edge, check registers.
    task automatic cycle();
        bit f1, f2;
        #1;
        ga = 0;
        gm = 0;
        if (!reset) begin
            if (alu_valid && mem_valid) begin
                gm = !m_last_mem;
                ga = m_last_mem;
            end else begin
                ga = alu_valid;
                gm = mem_valid;
            end
        end
        f1 = !reset && m_we && m_addr == int'(read_address1);
        f2 = !reset && m_we && m_addr == int'(read_address2);
        check("alu_ready", alu_ready, ga);
        check("mem_ready", mem_ready, gm);
        check("fwd1_valid", forward1_valid, f1);
        check("fwd2_valid", forward2_valid, f2);
        check("fwd1_data", forward1_data, f1 ? m_data : 32'h0);
        check("fwd2_data", forward2_data, f2 ? m_data : 32'h0);
        @(posedge clk);
        if (m_we) rf_model[m_addr] = m_data;
        if (reset) begin
            m_we = 0;
            m_addr = 0;
            m_data = '0;
            m_last_mem = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            if (m_we) m_busy[m_addr] = 0;
            if (issue_valid) m_busy[issue_address] = 1;
            m_we = ga || gm;
            if (ga) begin
                m_addr = alu_address;
                m_data = alu_data;
                m_last_mem = 0;
            end else if (gm) begin
                m_addr = mem_address;
                m_data = mem_data;
                m_last_mem = 1;
            end
        end
        #1;
        check("rf_we", rf_write_enable, m_we);
        check("rf_addr", rf_write_address, m_addr);
        check("rf_data", rf_write_data, m_data);
        check("busy", busy, busy_vec());
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
        reset = 1;
        cycle();
        cycle();
        reset = 0;
        check("reset_we", rf_write_enable, 0);
        check("reset_busy", busy, 0);

        // ALU-only write
        alu_valid = 1; alu_address = 3; alu_data = 32'hAA;
        #1 check("t1_ready", alu_ready, 1);
        cycle();
        alu_valid = 0;
        check("t1_we", rf_write_enable, 1);
        check("t1_addr", rf_write_address, 3);
        check("t1_data", rf_write_data, 32'hAA);
        cycle();
        check("t1_readback", rf_dut[3], 32'hAA);

        // Tie break: MEM first since ALU won last
        alu_valid = 1; alu_address = 4; alu_data = 32'h11;
        mem_valid = 1; mem_address = 5; mem_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t2_addr", rf_write_address, (i % 2 == 0) ? 5 : 4);
        end
        alu_valid = 0;
        mem_valid = 0;

        // Scoreboard round trip
        issue_valid = 1; issue_address = 7;
        cycle();
        issue_valid = 0;
        check("t3_set", busy[7], 1);
        mem_valid = 1; mem_address = 7; mem_data = 32'h1234;
        cycle();
        mem_valid = 0;
        check("t3_we", rf_write_enable, 1);
        cycle();
        check("t3_clear", busy[7], 0);
        issue_valid = 1;
        cycle();
        issue_valid = 0;
        mem_valid = 1;
        cycle();
        mem_valid = 0;
        issue_valid = 1;
        cycle();
        issue_valid = 0;
        check("t3_reissue", busy[7], 1);
        cycle();

        // Forwarding
        read_address1 = 9; read_address2 = 2;
        alu_valid = 1; alu_address = 9; alu_data = 32'hDEADBEEF;
        cycle();
        alu_valid = 0;
        check("t4_f1v", forward1_valid, 1);
        check("t4_f1d", forward1_data, 32'hDEADBEEF);
        check("t4_f2v", forward2_valid, 0);
        check("t4_f2d", forward2_data, 0);
        cycle();

        // Reset mid-operation (busy[7] still set from the re-issue)
        check("t5_busy_pre", busy, 32'h80);
        reset = 1; alu_valid = 1; alu_address = 1; alu_data = 32'h55;
        #1 check("t5_ready", alu_ready, 0);
        cycle();
        check("t5_we", rf_write_enable, 0);
        check("t5_busy", busy, 0);
        reset = 0; alu_valid = 0;
        cycle();
        check("t5_r1", rf_dut[1], 0);

        // Back-to-back writes to r0
        alu_valid = 1; alu_address = 0; alu_data = 32'h1;
        cycle();
        check("t6_first", rf_write_data, 32'h1);
        alu_data = 32'h2;
        cycle();
        alu_valid = 0;
        check("t6_we", rf_write_enable, 1);
        check("t6_second", rf_write_data, 32'h2);
        cycle();
        check("t6_readback", rf_dut[0], 32'h2);

        // Random traffic; producers hold their item until it transfers
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!alu_valid || ga) begin
                alu_valid = $urandom_range(0, 2) != 0;
                alu_address = 5'($urandom);
                alu_data = $urandom;
            end
            if (!mem_valid || gm) begin
                mem_valid = $urandom_range(0, 2) != 0;
                mem_address = 5'($urandom);
                mem_data = $urandom;
            end
            issue_valid = $urandom_range(0, 1);
            issue_address = 5'($urandom);
            read_address1 = 5'($urandom);
            read_address2 = $urandom_range(0, 1) ? rf_write_address : 5'($urandom);
            cycle();
        end
        reset = 0; alu_valid = 0; mem_valid = 0; issue_valid = 0;
        cycle();
        cycle();
        for (int i = 0; i < 32; i++) check("rf_final", rf_dut[i], rf_model[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
